// File: rtl/sop_sweep_tester_if.sv
// Bundle of the sweep request, golden mask, SoP feedback and sweep results.
// Optional macro SWEEP_FIRST_FAIL_EN adds first_fail_idx / first_fail_vld.
// Handshake: start is a single-cycle request. It is honoured only when
// state is IDLE or DONE. busy stays high from the accepted start edge until
// the last sample. done is a level that stays high until the next accepted
// start or reset.
interface sop_sweep_tester_if #(
  parameter int N_IN = 4
);
  logic                 start;
  logic [2**N_IN-1:0]   expected;
  logic                 s_in;
  logic [N_IN-1:0]      vec_out;
  logic                 busy;
  logic                 done;
  logic [2**N_IN-1:0]   table_out;
  logic [N_IN:0]        mismatch_cnt;
  logic                 pass;
  logic [1:0]           state;
`ifdef SWEEP_FIRST_FAIL_EN
  logic [N_IN-1:0]      first_fail_idx;
  logic                 first_fail_vld;
`endif

  modport master (
    output start, expected, s_in,
    input  vec_out, busy, done, table_out, mismatch_cnt, pass, state
`ifdef SWEEP_FIRST_FAIL_EN
    , first_fail_idx, first_fail_vld
`endif
  );

  modport slave (
    input  start, expected, s_in,
    output vec_out, busy, done, table_out, mismatch_cnt, pass, state
`ifdef SWEEP_FIRST_FAIL_EN
    , first_fail_idx, first_fail_vld
`endif
  );
endinterface

// File: rtl/sop_sweep_tester.sv
// Hardware truth-table sweeper for a 4-input sum-of-products block.
// It walks abcd = 0..2**N_IN-1 and holds each vector for SETTLE_CYCLES
// (legal range 1..255). It then samples s_in, builds table_out and counts
// mismatches against the expected mask.
// Optional macro SWEEP_FIRST_FAIL_EN records the first failing vector index.
// The FSM state is exposed on bus.state (0 IDLE, 1 SETTLE, 2 SAMPLE, 3 DONE).
module sop_sweep_tester #(
  parameter int N_IN          = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  sop_sweep_tester_if.slave bus
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] SAMPLE = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam logic [N_IN-1:0] LAST_IDX   = '1;
  localparam logic [N_IN-1:0] IDX_ONE    = N_IN'(1);
  localparam logic [7:0]      SETTLE_RLD = 8'(SETTLE_CYCLES - 1);

  logic [1:0]      state;
  logic [N_IN-1:0] index;
  logic [7:0]      settle_cnt;
  logic            miss;
  logic [N_IN:0]   next_cnt;

  assign bus.state = state;

  // Compare the current sample against the golden bit and form the updated count.
  always_comb begin
    miss     = 1'b0;
    next_cnt = bus.mismatch_cnt;
    miss     = (bus.s_in != bus.expected[index]);
    next_cnt = bus.mismatch_cnt + (N_IN+1)'(miss);
  end

  // Sweep sequencer: start, settle each vector, sample it, then finish.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      index            <= '0;
      settle_cnt       <= '0;
      bus.vec_out      <= '0;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
      bus.table_out    <= '0;
      bus.mismatch_cnt <= '0;
      bus.pass         <= 1'b0;
`ifdef SWEEP_FIRST_FAIL_EN
      bus.first_fail_idx <= '0;
      bus.first_fail_vld <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            index            <= '0;
            bus.vec_out      <= '0;
            bus.table_out    <= '0;
            bus.mismatch_cnt <= '0;
            bus.done         <= 1'b0;
            bus.pass         <= 1'b0;
            settle_cnt       <= SETTLE_RLD;
            bus.busy         <= 1'b1;
`ifdef SWEEP_FIRST_FAIL_EN
            bus.first_fail_idx <= '0;
            bus.first_fail_vld <= 1'b0;
`endif
            state            <= SETTLE;
          end
        end
        SETTLE: begin
          // vec_out is already stable; wait out the settle window.
          if (settle_cnt == 8'd0) begin
            state <= SAMPLE;
          end else begin
            settle_cnt <= settle_cnt - 8'd1;
          end
        end
        SAMPLE: begin
          bus.table_out[index] <= bus.s_in;
          bus.mismatch_cnt     <= next_cnt;
`ifdef SWEEP_FIRST_FAIL_EN
          if (miss && !bus.first_fail_vld) begin
            bus.first_fail_idx <= index;
            bus.first_fail_vld <= 1'b1;
          end
`endif
          if (index == LAST_IDX) begin
            // Terminal vector: the index never wraps past all-ones.
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            bus.pass <= (next_cnt == '0);
            state    <= DONE;
          end else begin
            index       <= index + IDX_ONE;
            bus.vec_out <= index + IDX_ONE;
            settle_cnt  <= SETTLE_RLD;
            state       <= SETTLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sop_sweep_tester.sv
// Bench for sop_sweep_tester: a table of whole-sweep vectors on a
// SETTLE_CYCLES=1 instance, plus hand sequences for reset, ignored start,
// mid-sweep reset and a SETTLE_CYCLES=3 instance.
module tb_sop_sweep_tester;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sop_sweep_tester_if #(.N_IN(4)) b1 ();
  sop_sweep_tester_if #(.N_IN(4)) b3 ();

  sop_sweep_tester #(.N_IN(4), .SETTLE_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  sop_sweep_tester #(.N_IN(4), .SETTLE_CYCLES(3)) dut3 (.clk(clk), .rst(rst), .bus(b3));

  // Reference SoP: s = a'cd' + bc + abd', vector MSB = a.
  function automatic logic sop_f(input logic [3:0] v);
    logic a, b, c, d;
    a = v[3]; b = v[2]; c = v[1]; d = v[0];
    return (~a & c & ~d) | (b & c) | (a & b & ~d);
  endfunction

  logic use_sop1;
  assign b1.s_in = use_sop1 ? sop_f(b1.vec_out) : 1'b0;
  assign b3.s_in = sop_f(b3.vec_out);

  int n_cmp = 0;
  int n_bad = 0;
  logic [3:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] all1();
    return {2'b0, b1.vec_out, b1.busy, b1.done, b1.table_out, b1.mismatch_cnt, b1.pass, b1.state};
  endfunction

  // Pulse start on b1 and run to done; optionally track vector stepping.
  task automatic sweep1(input logic steps, output int edges);
    @(negedge clk);
    b1.start = 1'b1;
    @(posedge clk); #1;
    b1.start = 1'b0;
    edges = 0;
    if (steps) begin
      check("start_busy", 32'(b1.busy), 32'd1);
      for (int v = 0; v < 16; v++) exp_q.push_back(4'(v));
    end
    while (edges < 200) begin
      @(posedge clk); #1;
      edges++;
      if (b1.done) break;
      if (steps) begin
        if (edges % 2 == 0) void'(exp_q.pop_front());
        check("vec_step", 32'(b1.vec_out), 32'(exp_q[0]));
        check("unsampled_zero", 32'(b1.table_out >> (edges / 2)), 32'd0);
      end
    end
    exp_q.delete();
    if (edges >= 200) check("done_timeout", 32'(b1.done), 32'd1);
  endtask

  typedef struct {
    logic [15:0] expected;
    logic        use_sop;
    logic [15:0] exp_table;
    int          exp_cnt;
    logic        exp_pass;
    logic [3:0]  exp_ff_idx;
    logic        exp_ff_vld;
  } vec_t;

  vec_t vt[5];
  int edges;
  int n;

  initial begin
    vt[0] = '{16'hD0C4, 1'b1, 16'hD0C4, 0,  1'b1, 4'd0, 1'b0};
    vt[1] = '{16'hD0C5, 1'b1, 16'hD0C4, 1,  1'b0, 4'd0, 1'b1};
    vt[2] = '{16'hD0C4, 1'b0, 16'h0000, 6,  1'b0, 4'd2, 1'b1};
    vt[3] = '{16'hFFFF, 1'b0, 16'h0000, 16, 1'b0, 4'd0, 1'b1};
    vt[4] = '{16'h0000, 1'b0, 16'h0000, 0,  1'b1, 4'd0, 1'b0};

    rst = 1'b1;
    use_sop1 = 1'b1;
    b1.start = 1'b0; b1.expected = 16'hD0C4;
    b3.start = 1'b0; b3.expected = 16'hD0C4;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state, held for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      check("reset_hold", all1(), 32'd0);
      check("reset_hold3", 32'({b3.vec_out, b3.busy, b3.done, b3.table_out, b3.mismatch_cnt, b3.pass}), 32'd0);
      @(posedge clk); #1;
    end

    // Table-driven full sweeps.
    for (int t = 0; t < 5; t++) begin
      b1.expected = vt[t].expected;
      use_sop1 = vt[t].use_sop;
      sweep1(t == 0, edges);
      check($sformatf("done_edge_%0d", t), 32'(edges), 32'd32);
      check($sformatf("table_%0d", t), 32'(b1.table_out), 32'(vt[t].exp_table));
      check($sformatf("mcnt_%0d", t), 32'(b1.mismatch_cnt), 32'(vt[t].exp_cnt));
      check($sformatf("pass_%0d", t), 32'(b1.pass), 32'(vt[t].exp_pass));
      check($sformatf("busy_%0d", t), 32'(b1.busy), 32'd0);
`ifdef SWEEP_FIRST_FAIL_EN
      check($sformatf("ff_vld_%0d", t), 32'(b1.first_fail_vld), 32'(vt[t].exp_ff_vld));
      if (vt[t].exp_ff_vld)
        check($sformatf("ff_idx_%0d", t), 32'(b1.first_fail_idx), 32'(vt[t].exp_ff_idx));
`endif
      repeat (3) @(posedge clk);
      #1 check($sformatf("done_hold_%0d", t), 32'(b1.done), 32'd1);
    end

    // Ignored start mid-sweep, then reset while vec_out = 5.
    b1.expected = 16'hD0C4;
    use_sop1 = 1'b1;
    @(negedge clk); b1.start = 1'b1;
    @(posedge clk); #1 b1.start = 1'b0;
    check("restart_clears", 32'({b1.done, b1.pass, b1.table_out}), 32'd0);
    n = 0;
    while (b1.vec_out != 4'd3 && n < 50) begin @(posedge clk); #1; n++; end
    check("vec3_edge", 32'(n), 32'd6);
    b1.start = 1'b1;
    @(posedge clk); #1 b1.start = 1'b0;
    check("ign_vec", 32'(b1.vec_out), 32'd3);
    check("ign_busy", 32'(b1.busy), 32'd1);
    check("ign_state", 32'(b1.state), 32'd2);
    @(posedge clk); #1;
    check("ign_advance", 32'(b1.vec_out), 32'd4);
    n = 0;
    while (b1.vec_out != 4'd5 && n < 50) begin @(posedge clk); #1; n++; end
    check("vec5_reached", 32'(b1.vec_out), 32'd5);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("midreset", all1(), 32'd0);
    @(posedge clk); #1;
    check("midreset_idle", all1(), 32'd0);
    sweep1(1'b0, edges);
    check("post_rst_edge", 32'(edges), 32'd32);
    check("post_rst_table", 32'(b1.table_out), 32'hD0C4);
    check("post_rst_pass", 32'(b1.pass), 32'd1);

    // SETTLE_CYCLES = 3: each vector held four cycles in total, done at edge 64.
    @(negedge clk); b3.start = 1'b1;
    @(posedge clk); #1 b3.start = 1'b0;
    edges = 0;
    while (edges < 300) begin
      @(posedge clk); #1;
      edges++;
      if (b3.done) break;
      check("s3_vec", 32'(b3.vec_out), 32'(edges / 4));
    end
    check("s3_done_edge", 32'(edges), 32'd64);
    check("s3_table", 32'(b3.table_out), 32'hD0C4);
    check("s3_mcnt", 32'(b3.mismatch_cnt), 32'd0);
    check("s3_pass", 32'(b3.pass), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
